// File: rtl/store_buffer.sv
// Word store FIFO draining into the shared memory port when IF is idle; 1-edge write, loads forwarded combinationally.
// Backpressure: st_ready drops while full; a starved full buffer raises stall_fetch to force one drain.
module store_buffer #(
  parameter int DEPTH        = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_hit,
  output logic [DATA_W-1:0]          ld_data,
  input  logic                       mem_busy,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       stall_fetch,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam int WA_W  = ADDR_W - 2;

  logic [WA_W-1:0]   ent_addr_q [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [PTR_W-1:0]  fwd_idx;
  logic              push, pop;
  logic              unused_lsbs;

  assign unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  always_comb begin
    full        = (count_q == CNT_W'(DEPTH));
    empty       = (count_q == '0);
    st_ready    = !full;
    stall_fetch = full && (starve_q >= SC_W'(STARVE_LIMIT));
    pop         = !empty && (!mem_busy || stall_fetch);
    push        = st_valid && !full;
    mem_we      = pop;
    mem_addr    = {ent_addr_q[head_q], 2'b00};
    mem_wdata   = ent_data_q[head_q];
    count       = count_q;

    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    // Only a full buffer that IF keeps blocking accumulates starvation.
    starve_d = starve_q;
    if (pop || !full)                     starve_d = '0;
    else if (mem_busy && !stall_fetch)    starve_d = starve_q + SC_W'(1);
  end

  // Oldest to youngest so the youngest match overrides; the entry being popped stays visible.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    fwd_idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (ent_addr_q[fwd_idx] == ld_addr[ADDR_W-1:2])) begin
        ld_hit  = 1'b1;
        ld_data = ent_data_q[fwd_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[tail_q] <= st_addr[ADDR_W-1:2];
      ent_data_q[tail_q] <= st_data;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer: a queue-based reference model predicts
// every cycle, and a scoreboard monitor checks each drain against the order of accepted stores.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, st_ready, ld_hit, mem_busy, mem_we, stall_fetch, empty, full;
  logic [31:0] st_addr, st_data, ld_addr, ld_data, mem_addr, mem_wdata;
  logic [2:0]  count;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall_fetch(stall_fetch), .count(count), .empty(empty), .full(full)
  );

  int   checks = 0;
  int   passed = 0;
  ent_t mq[$];
  ent_t exp_q[$];
  int   starve = 0;
  logic [31:0] tmem [0:7];
  logic obs_ready, obs_full, obs_empty, obs_we, obs_stall, obs_hit;
  logic [2:0]  obs_count;
  logic [31:0] obs_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: every drain must match the oldest accepted, not-yet-drained store.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst && mem_we === 1'b1) begin
        chk("drain_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("drain_addr", 64'(mem_addr), 64'({e.a[31:2], 2'b00}));
          chk("drain_data", 64'(mem_wdata), 64'(e.d));
          tmem[mem_addr[4:2]] = mem_wdata;
        end
      end
    end
  end

  // One clock with inputs already driven: predict from the model, compare, then advance the model.
  task automatic cycle();
    int          n;
    bit          pfull, pstall, pdrain, ppush, phit;
    logic [31:0] pdata;
    @(negedge clk);
    n      = mq.size();
    pfull  = (n == DEPTH);
    pstall = pfull && (starve >= LIMIT);
    pdrain = (n > 0) && (!mem_busy || pstall);
    ppush  = st_valid && !pfull;
    phit   = 1'b0;
    pdata  = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (mq[i].a[31:2] == ld_addr[31:2]) begin
        phit  = 1'b1;
        pdata = mq[i].d;
        break;
      end
    end
    chk("count", 64'(count), 64'(n));
    chk("full", 64'(full), 64'(pfull));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("st_ready", 64'(st_ready), 64'(!pfull));
    chk("stall_fetch", 64'(stall_fetch), 64'(pstall));
    chk("mem_we", 64'(mem_we), 64'(pdrain));
    chk("ld_hit", 64'(ld_hit), 64'(phit));
    chk("ld_data", 64'(ld_data), 64'(pdata));
    obs_ready = st_ready; obs_full = full; obs_empty = empty; obs_we = mem_we;
    obs_stall = stall_fetch; obs_hit = ld_hit; obs_data = ld_data; obs_count = count;
    @(posedge clk);
    if (ppush) begin
      mq.push_back(ent_t'{st_addr, st_data});
      exp_q.push_back(ent_t'{st_addr, st_data});
    end
    if (pdrain) void'(mq.pop_front());
    if (pdrain || !pfull) starve = 0;
    else if (mem_busy && !pstall) starve++;
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_addr = a; st_data = d;
    cycle();
    st_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic busy);
    mem_busy = busy; st_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int stall_at;
    for (int i = 0; i < 8; i++) tmem[i] = '0;
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; ld_addr = '0; mem_busy = 1'b0;
    #2;
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_ready", 64'(st_ready), 64'(1));
    chk("rst_we", 64'(mem_we), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_stall", 64'(stall_fetch), 64'(0));
    chk("rst_hit", 64'(ld_hit), 64'(0));
    @(posedge clk); #1; rst = 1'b0;

    // Four stores to word 0 while IF holds the port
    mem_busy = 1'b1;
    for (int k = 1; k <= 4; k++) store(32'h0, 32'(k * 10));
    st_valid = 1'b1; st_addr = 32'h0; st_data = 32'd99; ld_addr = 32'h0;
    cycle();
    st_valid = 1'b0;
    chk("t2_full", 64'(obs_full), 64'(1));
    chk("t2_ready", 64'(obs_ready), 64'(0));
    chk("t2_hit0", 64'(obs_hit), 64'(1));
    chk("t2_data0", 64'(obs_data), 64'(40));
    ld_addr = 32'h4;
    cycle();
    chk("t2_hit4", 64'(obs_hit), 64'(0));

    // Release the port: four back-to-back drains
    mem_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t3_we", 64'(obs_we), 64'(1));
    end
    cycle();
    chk("t3_empty", 64'(obs_empty), 64'(1));
    chk("t3_mem0", 64'(tmem[0]), 64'(40));

    // Starvation: full and blocked until a drain is forced
    mem_busy = 1'b1;
    for (int k = 0; k < 4; k++) store(32'(k * 4 + 16), $urandom);
    stall_at = 0;
    for (int k = 1; k <= 20 && stall_at == 0; k++) begin
      cycle();
      if (obs_stall) stall_at = k;
    end
    chk("t4_stall_cycle", 64'(stall_at), 64'(LIMIT + 1));
    cycle();
    chk("t4_count_after", 64'(obs_count), 64'(3));
    chk("t4_stall_after", 64'(obs_stall), 64'(0));
    idle(4, 1'b0);

    // Simultaneous push/pop at count 2 across pointer wrap
    mem_busy = 1'b1;
    store(32'h40, 32'd100);
    store(32'h44, 32'd101);
    mem_busy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      store(32'h48 + 32'(k * 4), 32'(200 + k));
      chk("t5_count", 64'(obs_count), 64'(2));
    end
    idle(3, 1'b0);

    // A store pushed this cycle is not yet visible to forwarding
    mem_busy = 1'b1; ld_addr = 32'h8;
    store(32'h8, 32'd7);
    chk("t6_same_cycle_hit", 64'(obs_hit), 64'(0));
    cycle();
    chk("t6_next_hit", 64'(obs_hit), 64'(1));
    chk("t6_next_data", 64'(obs_data), 64'(7));
    idle(2, 1'b0);

    // Async reset in the middle of a drain with three entries queued
    mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) store(32'(k * 4), $urandom);
    mem_busy = 1'b0;
    #1; rst = 1'b1; #1;
    chk("rst_mid_count", 64'(count), 64'(0));
    chk("rst_mid_empty", 64'(empty), 64'(1));
    chk("rst_mid_we", 64'(mem_we), 64'(0));
    mq.delete(); exp_q.delete(); starve = 0;
    @(posedge clk); #1; rst = 1'b0;

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      st_valid = ($urandom_range(0, 2) != 0);
      st_addr  = 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3));
      st_data  = $urandom;
      ld_addr  = 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3));
      mem_busy = ($urandom_range(0, 4) != 0);
      cycle();
    end
    idle(8, 1'b0);
    chk("all_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
